// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA sync decoder: counter width, saturation
// limit, hsync-loss timeout, the lock FSM state encoding and a saturating
// increment helper used by every measurement counter.
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int CNT_W = 11;
    localparam logic [CNT_W-1:0] CNT_SAT = 11'd2047;

    localparam int TO_W = 12;
    localparam logic [TO_W-1:0] TIMEOUT = 12'd4095;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_e;

    // Increment that sticks at CNT_SAT instead of wrapping to zero.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_edge_det.sv
// ----------------------------------------------------------------------------
// vga_edge_det
// Falling-edge detector: registers the previous sample of sig_i and flags a
// 1->0 transition against the current input.
//
// Ports
//   clk     : clock
//   rst     : asynchronous active-high reset, loads RESET_LEVEL as history
//   sig_i   : monitored signal
//   fall_o  : high in the cycle where sig_i is 0 and its previous sample was 1
// ----------------------------------------------------------------------------
module vga_edge_det #(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic fall_o
);

    logic prev_q;

    // A history of RESET_LEVEL (the deasserted level) means no edge is seen on
    // the first clock after reset unless the input is actually low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= RESET_LEVEL;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            prev_q <= sig_i;
        end
    end

    assign fall_o = prev_q & ~sig_i;

endmodule

// File: rtl/vga_sync_decoder.sv
// ----------------------------------------------------------------------------
// vga_sync_decoder
// Recovers video timing from hsync/vsync/blank: measures line length, active
// width, frame height and active height, locks once two consecutive full
// frames agree, and reports the current pixel coordinate.
//
// Ports
//   vclock      : pixel clock, rising-edge active
//   reset       : asynchronous active-high reset
//   hsync/vsync : active-low sync inputs
//   blank       : high outside the active area
//   x, y        : recovered active column / active line
//   active      : pixel is active and decoder is locked
//   h_total, h_active, v_total, v_active : stored measurements
//   locked      : high exactly while the FSM is in LOCKED
//   frame_start : one-cycle pulse at each vsync fall while LOCKED
// ----------------------------------------------------------------------------
module vga_sync_decoder
    import vga_pkg::*;
(
    input  logic             vclock,
    input  logic             reset,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             blank,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic             locked,
    output logic             frame_start
);

    localparam logic [TO_W-1:0] TIMEOUT_M1 = TIMEOUT - 12'd1;

    logic hs_fall, vs_fall, bl_fall;

    vga_edge_det #(.RESET_LEVEL(1'b1)) u_hs_det (
        .clk(vclock), .rst(reset), .sig_i(hsync), .fall_o(hs_fall)
    );
    vga_edge_det #(.RESET_LEVEL(1'b1)) u_vs_det (
        .clk(vclock), .rst(reset), .sig_i(vsync), .fall_o(vs_fall)
    );
    vga_edge_det #(.RESET_LEVEL(1'b1)) u_bl_det (
        .clk(vclock), .rst(reset), .sig_i(blank), .fall_o(bl_fall)
    );

    state_e          state_q, state_d;
    cnt_t            hc_q, hc_d;            // clocks in current line
    cnt_t            ac_q, ac_d;            // blank-low clocks in current line
    logic            line_act_q, line_act_d;
    cnt_t            cand_ht_q, cand_ht_d;
    cnt_t            cand_ha_q, cand_ha_d;
    cnt_t            vc_q, vc_d;            // lines in current frame
    cnt_t            val_q, val_d;          // active lines in current frame
    logic [TO_W-1:0] to_q, to_d;            // clocks since last hsync fall
    cnt_t            x_q, x_d;
    cnt_t            y_q, y_d;
    cnt_t            h_total_q, h_total_d;
    cnt_t            h_active_q, h_active_d;
    cnt_t            v_total_q, v_total_d;
    cnt_t            v_active_q, v_active_d;
    logic            active_q, active_d;
    logic            locked_q, locked_d;
    logic            frame_start_q, frame_start_d;

    cnt_t vc_end, val_end;  // frame counts with the same-edge line end applied
    logic timeout, match, store, clear;

    // ------------------------------------------------------------------------
    // Measurement datapath
    // ------------------------------------------------------------------------
    always_comb begin
        // The clock carrying the hsync fall is the first clock of the new line.
        hc_d = hs_fall ? cnt_t'(1) : sat_inc(hc_q);

        if (hs_fall) begin
            ac_d = blank ? '0 : cnt_t'(1);
        end else begin
            ac_d = blank ? ac_q : sat_inc(ac_q);
        end

        line_act_d = hs_fall ? ~blank : (line_act_q | ~blank);

        cand_ht_d = hs_fall ? hc_q : cand_ht_q;
        // Vertical-blanking lines would report zero width, so only lines that
        // carried pixels update the active-width candidate.
        cand_ha_d = (hs_fall && (ac_q != '0)) ? ac_q : cand_ha_q;

        // Line end is folded in before the vsync clear, so a line whose hsync
        // falls together with vsync still counts toward the ending frame.
        vc_end  = hs_fall ? sat_inc(vc_q) : vc_q;
        val_end = (hs_fall && line_act_q) ? sat_inc(val_q) : val_q;
        vc_d    = vs_fall ? '0 : vc_end;
        val_d   = vs_fall ? '0 : val_end;

        if (bl_fall) begin
            x_d = '0;
        end else if (!blank) begin
            x_d = sat_inc(x_q);
        end else begin
            x_d = x_q;
        end

        if (vs_fall) begin
            y_d = '0;
        end else if (hs_fall && line_act_q) begin
            y_d = sat_inc(y_q);
        end else begin
            y_d = y_q;
        end

        to_d    = hs_fall ? '0 : ((to_q == TIMEOUT) ? to_q : to_q + 12'd1);
        // Fires on the 4095th consecutive clock without an hsync fall.
        timeout = ~hs_fall & (to_q >= TIMEOUT_M1);

        match = (cand_ht_d == h_total_q) && (cand_ha_d == h_active_q) &&
                (vc_end == v_total_q) && (val_end == v_active_q);
    end

    // ------------------------------------------------------------------------
    // Lock FSM: next state and store/clear strobes
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so no path leaves a combinational output
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        store   = 1'b0;
        clear   = 1'b0;

        if (timeout) begin
            state_d = ST_SEARCH;
            clear   = 1'b1;
        end else if (vs_fall) begin
            case (state_q)
                // First vsync fall only aligns us; the partial frame is ignored.
                ST_SEARCH:  state_d = ST_MEASURE;
                ST_MEASURE: begin
                    store   = 1'b1;
                    state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (match) begin
                        state_d = ST_LOCKED;
                    end else begin
                        store = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!match) begin
                        store   = 1'b1;
                        state_d = ST_CHECK;
                    end
                end
                default:    state_d = ST_SEARCH;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        h_total_d  = h_total_q;
        h_active_d = h_active_q;
        v_total_d  = v_total_q;
        v_active_d = v_active_q;
        if (clear) begin
            h_total_d  = '0;
            h_active_d = '0;
            v_total_d  = '0;
            v_active_d = '0;
        end else if (store) begin
            h_total_d  = cand_ht_d;
            h_active_d = cand_ha_d;
            v_total_d  = vc_end;
            v_active_d = val_end;
        end

        locked_d      = (state_d == ST_LOCKED);
        active_d      = locked_d & ~blank;
        frame_start_d = vs_fall & (state_q == ST_LOCKED) & ~timeout;
    end

    always_ff @(posedge vclock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_SEARCH;
            hc_q          <= '0;
            ac_q          <= '0;
            line_act_q    <= 1'b0;
            cand_ht_q     <= '0;
            cand_ha_q     <= '0;
            vc_q          <= '0;
            val_q         <= '0;
            to_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            h_total_q     <= '0;
            h_active_q    <= '0;
            v_total_q     <= '0;
            v_active_q    <= '0;
            active_q      <= 1'b0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hc_q          <= hc_d;
            ac_q          <= ac_d;
            line_act_q    <= line_act_d;
            cand_ht_q     <= cand_ht_d;
            cand_ha_q     <= cand_ha_d;
            vc_q          <= vc_d;
            val_q         <= val_d;
            to_q          <= to_d;
            x_q           <= x_d;
            y_q           <= y_d;
            h_total_q     <= h_total_d;
            h_active_q    <= h_active_d;
            v_total_q     <= v_total_d;
            v_active_q    <= v_active_d;
            active_q      <= active_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign h_total     = h_total_q;
    assign h_active    = h_active_q;
    assign v_total     = v_total_q;
    assign v_active    = v_active_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_decoder
// Drives synthetic VGA timings into vga_sync_decoder: lock acquisition on a
// 1344-clock line, pixel coordinates, asynchronous reset and relock, a table
// of frame-level scenarios (wrong line length, same-edge h/v sync), and the
// hsync-loss timeout.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_sync_decoder;
    import vga_pkg::*;

    logic        vclock = 1'b0;
    logic        reset;
    logic        hsync, vsync, blank;
    logic [10:0] x, y, h_total, h_active, v_total, v_active;
    logic        active, locked, frame_start;

    vga_sync_decoder dut (
        .vclock      (vclock),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .x           (x),
        .y           (y),
        .active      (active),
        .h_total     (h_total),
        .h_active    (h_active),
        .v_total     (v_total),
        .v_active    (v_active),
        .locked      (locked),
        .frame_start (frame_start)
    );

    always #5 vclock = ~vclock;

    typedef struct {
        int h_tot;
        int h_act;
        int hs_start;
        int hs_len;
        int v_tot;
        int v_act;
        int vs_line;
        int vs_clk;
        int vs_len;
    } timing_t;

    typedef struct {
        string   name;
        timing_t t;
        int      frames;
        state_e  st;
        int      ht;
        int      ha;
        int      vt;
        int      va;
    } scen_t;

    int   total = 0;
    int   bad   = 0;
    int   cur_line, cur_clk, since_hs, vs_cnt;
    logic prev_hs, prev_vs;
    bit   watch_lock;

    timing_t t_w, t_s, t_l, t_e;
    scen_t   scen[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " x"}, x, 0);
        check({tag, " y"}, y, 0);
        check({tag, " active"}, active, 0);
        check({tag, " locked"}, locked, 0);
        check({tag, " frame_start"}, frame_start, 0);
        check({tag, " h_total"}, h_total, 0);
        check({tag, " h_active"}, h_active, 0);
        check({tag, " v_total"}, v_total, 0);
        check({tag, " v_active"}, v_active, 0);
        check({tag, " state"}, dut.state_q, ST_SEARCH);
    endtask

    task automatic restart_position();
        cur_line = 0;
        cur_clk  = 0;
        prev_hs  = 1'b1;
        prev_vs  = 1'b1;
        since_hs = 0;
        vs_cnt   = 0;
    endtask

    // Drive one pixel clock of timing t at the current position, then sample.
    task automatic step(input timing_t t);
        int   p, ps;
        logic hs_fell, vs_fell;
        p  = cur_line * t.h_tot + cur_clk;
        ps = t.vs_line * t.h_tot + t.vs_clk;
        hsync = !(cur_clk >= t.hs_start && cur_clk < t.hs_start + t.hs_len);
        vsync = !(p >= ps && p < ps + t.vs_len * t.h_tot);
        blank = !(cur_clk < t.h_act && cur_line < t.v_act);
        @(posedge vclock);
        #1;
        hs_fell  = prev_hs & ~hsync;
        vs_fell  = prev_vs & ~vsync;
        prev_hs  = hsync;
        prev_vs  = vsync;
        since_hs = hs_fell ? 0 : since_hs + 1;
        if (vs_fell) begin
            vs_cnt++;
            if (watch_lock) begin
                if (vs_cnt == 1) begin
                    check("acq vs1 state", dut.state_q, ST_MEASURE);
                    check("acq vs1 locked", locked, 0);
                end else if (vs_cnt == 2) begin
                    check("acq vs2 state", dut.state_q, ST_CHECK);
                    check("acq vs2 locked", locked, 0);
                end else if (vs_cnt == 3) begin
                    check("acq vs3 locked", locked, 1);
                    check("acq vs3 state", dut.state_q, ST_LOCKED);
                    check("acq vs3 frame_start", frame_start, 0);
                    watch_lock = 1'b0;
                end
            end
        end
        cur_clk++;
        if (cur_clk == t.h_tot) begin
            cur_clk = 0;
            cur_line++;
            if (cur_line == t.v_tot) cur_line = 0;
        end
    endtask

    task automatic run_frames(input timing_t t, input int n);
        repeat (n * t.v_tot * t.h_tot) step(t);
    endtask

    // Advance until the next step() would drive (line, clk).
    task automatic run_to(input timing_t t, input int line, input int clk);
        int budget;
        budget = t.v_tot * t.h_tot;
        while (!(cur_line == line && cur_clk == clk) && budget > 0) begin
            step(t);
            budget--;
        end
        check("run_to reached position", budget > 0, 1);
    endtask

    task automatic idle_step();
        hsync = 1'b1;
        vsync = 1'b1;
        blank = 1'b1;
        @(posedge vclock);
        #1;
        prev_hs  = 1'b1;
        prev_vs  = 1'b1;
        since_hs = since_hs + 1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        t_w = '{h_tot: 1344, h_act: 1024, hs_start: 1048, hs_len: 136,
                v_tot: 5, v_act: 3, vs_line: 3, vs_clk: 0, vs_len: 1};
        t_s = '{h_tot: 64, h_act: 48, hs_start: 50, hs_len: 8,
                v_tot: 26, v_act: 20, vs_line: 22, vs_clk: 0, vs_len: 2};
        t_l = t_s;
        t_l.h_tot = 65;
        t_e = t_s;
        t_e.vs_clk = 50;   // vsync falls on the same clock as hsync

        scen[0] = '{name: "long line frame", t: t_l, frames: 1, st: ST_CHECK,
                    ht: 65, ha: 48, vt: 26, va: 20};
        scen[1] = '{name: "nominal 1", t: t_s, frames: 1, st: ST_CHECK,
                    ht: 64, ha: 48, vt: 26, va: 20};
        scen[2] = '{name: "nominal 2 relock", t: t_s, frames: 1, st: ST_LOCKED,
                    ht: 64, ha: 48, vt: 26, va: 20};
        // Moving vsync later within line 22 stretches the transition frame by one line.
        scen[3] = '{name: "same-edge shift", t: t_e, frames: 1, st: ST_CHECK,
                    ht: 64, ha: 48, vt: 27, va: 20};
        scen[4] = '{name: "same-edge steady", t: t_e, frames: 1, st: ST_CHECK,
                    ht: 64, ha: 48, vt: 26, va: 20};

        // ---------------- reset state ----------------
        hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
        reset = 1'b1;
        watch_lock = 1'b0;
        restart_position();
        repeat (3) @(posedge vclock);
        #1;
        check_zero("reset");
        reset = 1'b0;

        // ---------------- wide timing: acquisition ----------------
        watch_lock = 1'b1;
        run_frames(t_w, 3);
        check("wide locked", locked, 1);
        check("wide h_total", h_total, 1344);
        check("wide h_active", h_active, 1024);
        check("wide v_total", v_total, 5);
        check("wide v_active", v_active, 3);

        // ---------------- pixel coordinates while locked ----------------
        step(t_w);                                   // line 0, clk 0
        check("first pixel x", x, 0);
        check("first pixel y", y, 0);
        check("first pixel active", active, 1);
        run_to(t_w, 0, 1023);
        step(t_w);
        check("last pixel x", x, 1023);
        check("last pixel active", active, 1);
        step(t_w);                                   // line 0, clk 1024
        check("after last pixel active", active, 0);
        check("after last pixel x hold", x, 1023);
        run_to(t_w, 2, 0);
        step(t_w);
        check("last line y", y, 2);
        check("last line x", x, 0);
        run_to(t_w, 3, 0);
        step(t_w);                                   // vsync fall while locked
        check("frame_start pulse", frame_start, 1);
        check("locked stays", locked, 1);
        step(t_w);
        check("frame_start one cycle", frame_start, 0);

        // ---------------- asynchronous reset mid-line ----------------
        run_to(t_w, 3, 600);
        step(t_w);
        #1;
        reset = 1'b1;
        #1;
        check_zero("async reset");
        hsync = 1'b1; vsync = 1'b1; blank = 1'b1;
        repeat (2) @(posedge vclock);
        #1;
        reset = 1'b0;
        restart_position();

        // ---------------- relock on small timing ----------------
        watch_lock = 1'b1;
        run_frames(t_s, 3);
        check("relock locked", locked, 1);
        check("relock h_total", h_total, 64);
        check("relock h_active", h_active, 48);
        check("relock v_total", v_total, 26);
        check("relock v_active", v_active, 20);

        // ---------------- frame-level scenario table ----------------
        for (int i = 0; i < 5; i++) begin
            run_frames(scen[i].t, scen[i].frames);
            check({scen[i].name, " state"}, dut.state_q, scen[i].st);
            check({scen[i].name, " locked"}, locked, (scen[i].st == ST_LOCKED) ? 1 : 0);
            check({scen[i].name, " h_total"}, h_total, scen[i].ht);
            check({scen[i].name, " h_active"}, h_active, scen[i].ha);
            check({scen[i].name, " v_total"}, v_total, scen[i].vt);
            check({scen[i].name, " v_active"}, v_active, scen[i].va);
        end
        run_frames(t_e, 1);
        check("same-edge relock", locked, 1);
        check("same-edge v_total", v_total, 26);

        // ---------------- hsync loss timeout ----------------
        while (since_hs < 4094) idle_step();
        check("timeout-1 locked", locked, 1);
        check("timeout-1 h_total", h_total, 64);
        idle_step();
        check("timeout state", dut.state_q, ST_SEARCH);
        check("timeout locked", locked, 0);
        check("timeout h_total", h_total, 0);
        check("timeout h_active", h_active, 0);
        check("timeout v_total", v_total, 0);
        check("timeout v_active", v_active, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
